// File: rtl/airi5c_lsu_align_if.sv
// Request/response and data-bus signal bundle for the load/store alignment unit.
// Signal names drop the _i/_o direction suffix; direction comes from the modport.
// The unit sits on the slave side; the core/memory environment is the master side.
interface airi5c_lsu_align_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  // request from the EX/WB stage
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  // data-memory bus beat
  logic            bus_valid;
  logic            bus_ready;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [NB-1:0]   bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic [XLEN-1:0] bus_rdata;

  // response back to the pipeline
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/airi5c_lsu_align.sv
// Load/store alignment unit: lane-aligns store data, builds byte enables,
// splits line-crossing accesses into two bus beats (or flags them as errors)
// and merges/extends load data into a registered one-cycle response.
module airi5c_lsu_align #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  airi5c_lsu_align_if.slave io
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            we_q, we_d;
  logic            split_q, split_d;

  // decode of the incoming request (only meaningful on accept)
  logic [OFFW-1:0] req_off;
  logic [4:0]      req_bytes;
  logic            req_split;
  logic            req_illegal;

  assign req_off     = io.req_addr[OFFW-1:0];
  assign req_bytes   = 5'd1 << io.req_size;
  assign req_split   = (5'(req_off) + req_bytes) > 5'(NB);
  assign req_illegal = (XLEN == 32) && (io.req_size == 2'b11);

  // decode of the registered request
  logic [OFFW-1:0]   off_q;
  logic [4:0]        bytes_q;
  logic [OFFW+2:0]   shamt;
  logic [XLEN-1:0]   beat0_addr;
  logic [XLEN-1:0]   beat1_addr;
  logic [2*NB-1:0]   be_base;
  logic [2*NB-1:0]   be_full;
  logic [2*XLEN-1:0] wdata_sh;

  assign off_q      = addr_q[OFFW-1:0];
  assign bytes_q    = 5'd1 << size_q;
  assign shamt      = {off_q, 3'b000};
  assign beat0_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign beat1_addr = beat0_addr + XLEN'(NB);
  assign be_base    = ((2*NB)'(1) << bytes_q) - (2*NB)'(1);
  assign be_full    = be_base << off_q;
  assign wdata_sh   = {{XLEN{1'b0}}, wdata_q} << shamt;

  // Load merge works on the buffers as they will be after this cycle's beat,
  // so the final merged value can be registered on the last bus_ready edge.
  logic [XLEN-1:0] merge_lo;
  logic [XLEN-1:0] merge_hi;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] merged;
  logic [IW-1:0]   sbit_idx;
  logic            sign_fill;

  assign merge_lo  = (state_q == S_BEAT0) ? io.bus_rdata : lo_q;
  assign merge_hi  = (state_q == S_BEAT1) ? io.bus_rdata :
                     (state_q == S_BEAT0) ? '0 : hi_q;
  assign raw       = XLEN'({merge_hi, merge_lo} >> shamt);
  assign sbit_idx  = IW'({bytes_q - 5'd1, 3'b111});
  assign sign_fill = !uns_q && (bytes_q != 5'(NB)) && raw[sbit_idx];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (5'(gi) < bytes_q) ? raw[8*gi +: 8] :
                                 (sign_fill ? 8'hFF : 8'h00);
    end
  endgenerate

  assign io.rsp_rdata = rdata_q;

  // FSM next state, request capture, beat generation and response strobes
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    split_d = split_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;

    io.req_ready = 1'b0;
    io.bus_valid = 1'b0;
    io.bus_we    = 1'b0;
    io.bus_addr  = '0;
    io.bus_be    = '0;
    io.bus_wdata = '0;
    io.rsp_valid = 1'b0;
    io.rsp_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) begin
          addr_d  = io.req_addr;
          wdata_d = io.req_wdata;
          size_d  = io.req_size;
          uns_d   = io.req_unsigned;
          we_d    = io.req_we;
          split_d = req_split;
          if ((req_split && !MISALIGN_EN) || req_illegal) begin
            rdata_d = '0;
            state_d = S_ERR;
          end else begin
            state_d = S_BEAT0;
          end
        end
      end

      S_BEAT0: begin
        io.bus_valid = 1'b1;
        io.bus_we    = we_q;
        io.bus_addr  = beat0_addr;
        io.bus_be    = be_full[NB-1:0];
        io.bus_wdata = wdata_sh[XLEN-1:0];
        if (io.bus_ready) begin
          lo_d = io.bus_rdata;
          hi_d = '0;
          if (split_q) begin
            state_d = S_BEAT1;
          end else begin
            rdata_d = we_q ? '0 : merged;
            state_d = S_RESP;
          end
        end
      end

      S_BEAT1: begin
        io.bus_valid = 1'b1;
        io.bus_we    = we_q;
        io.bus_addr  = beat1_addr;
        io.bus_be    = be_full[2*NB-1:NB];
        io.bus_wdata = wdata_sh[2*XLEN-1:XLEN];
        if (io.bus_ready) begin
          hi_d    = io.bus_rdata;
          rdata_d = we_q ? '0 : merged;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        io.rsp_valid = 1'b1;
        state_d      = S_IDLE;
      end

      S_ERR: begin
        io.rsp_valid = 1'b1;
        io.rsp_err   = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any in-flight beat
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_airi5c_lsu_align.sv
// Bench for airi5c_lsu_align (XLEN=32): one instance with splitting enabled,
// one with splitting disabled; a byte-level reference model predicts beats,
// byte enables, store lanes, load result, error flag and latency.
module tb_airi5c_lsu_align;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  airi5c_lsu_align_if #(.XLEN(32)) ifa ();
  airi5c_lsu_align_if #(.XLEN(32)) ife ();

  airi5c_lsu_align #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .io    (ifa)
  );

  airi5c_lsu_align #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_e (
    .clk_i (clk),
    .rst_ni(rst_n),
    .io    (ife)
  );

  // shared stimulus; valid/ready gated towards the selected instance
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  assign ifa.req_valid    = req_valid & ~sel;
  assign ife.req_valid    = req_valid & sel;
  assign ifa.bus_ready    = bus_ready & ~sel;
  assign ife.bus_ready    = bus_ready & sel;
  assign ifa.req_we       = req_we;
  assign ife.req_we       = req_we;
  assign ifa.req_size     = req_size;
  assign ife.req_size     = req_size;
  assign ifa.req_unsigned = req_unsigned;
  assign ife.req_unsigned = req_unsigned;
  assign ifa.req_addr     = req_addr;
  assign ife.req_addr     = req_addr;
  assign ifa.req_wdata    = req_wdata;
  assign ife.req_wdata    = req_wdata;
  assign ifa.bus_rdata    = bus_rdata;
  assign ife.bus_rdata    = bus_rdata;

  logic        o_req_ready, o_bus_valid, o_bus_we, o_rsp_valid, o_rsp_err;
  logic [31:0] o_bus_addr, o_bus_wdata, o_rsp_rdata;
  logic [3:0]  o_bus_be;

  assign o_req_ready = sel ? ife.req_ready : ifa.req_ready;
  assign o_bus_valid = sel ? ife.bus_valid : ifa.bus_valid;
  assign o_bus_we    = sel ? ife.bus_we    : ifa.bus_we;
  assign o_bus_addr  = sel ? ife.bus_addr  : ifa.bus_addr;
  assign o_bus_be    = sel ? ife.bus_be    : ifa.bus_be;
  assign o_bus_wdata = sel ? ife.bus_wdata : ifa.bus_wdata;
  assign o_rsp_valid = sel ? ife.rsp_valid : ifa.rsp_valid;
  assign o_rsp_err   = sel ? ife.rsp_err   : ifa.rsp_err;
  assign o_rsp_rdata = sel ? ife.rsp_rdata : ifa.rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  // One transaction: s selects the no-split instance, wait0 stalls beat 0,
  // garbage keeps req_valid high with junk while busy, rst_b1 resets in beat 1.
  task automatic run_req(input bit s, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd0, input logic [31:0] rd1,
                         input int wait0, input bit garbage, input bit rst_b1,
                         input string tag);
    int          bytes, nbeats, e_lat, beat, wc, rsp_c;
    bit          e_err, seen, done, rst_hit;
    logic [31:0] e_addr[2], e_w[2], val, a, rdw, e_res, obs_rdata;
    logic [3:0]  e_be[2];
    logic        obs_err;

    // reference model: walk the accessed bytes one by one
    bytes  = 1 << size;
    e_err  = (size == 2'd3) || (s && ((int'(addr[1:0]) + bytes) > 4));
    nbeats = 0;
    val    = '0;
    for (int j = 0; j < 2; j++) begin
      e_addr[j] = (addr & 32'hFFFF_FFFC) + 32'(4 * j);
      e_be[j]   = '0;
      e_w[j]    = '0;
    end
    if (!e_err) begin
      nbeats = 1;
      for (int k = 0; k < bytes; k++) begin
        int j, lane;
        a    = addr + 32'(k);
        j    = ((a >> 2) != (addr >> 2)) ? 1 : 0;
        lane = int'(a[1:0]);
        if (j == 1) nbeats = 2;
        e_be[j][lane] = 1'b1;
        e_w[j][8*lane +: 8] = wdata[8*k +: 8];
        rdw = (j == 1) ? rd1 : rd0;
        val[8*k +: 8] = rdw[8*lane +: 8];
      end
      if (!uns && bytes < 4 && val[8*bytes-1])
        val = val | ~((32'd1 << (8*bytes)) - 32'd1);
    end
    e_res = (we || e_err) ? 32'd0 : val;
    e_lat = e_err ? 1 : 1 + nbeats + wait0;

    @(negedge clk);
    chk({tag, "_idle_ready"}, o_req_ready, 1);
    sel = s; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);

    beat = 0; wc = 0; rsp_c = 0; seen = 0; done = 0; rst_hit = 0;
    obs_rdata = '0; obs_err = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      req_valid = garbage;
      if (garbage) begin
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      chk({tag, "_busy_ready"}, o_req_ready, 0);
      if (o_rsp_valid) begin
        seen = 1; done = 1; rsp_c = cyc; req_valid = 1'b0;
        obs_rdata = o_rsp_rdata; obs_err = o_rsp_err;
        chk({tag, "_rsp_busvalid"}, o_bus_valid, 0);
      end else if (o_bus_valid) begin
        if (beat >= nbeats) begin
          chk({tag, "_extra_beat"}, beat + 1, nbeats);
          done = 1;
        end else begin
          chk({tag, "_addr"}, o_bus_addr, e_addr[beat]);
          chk({tag, "_be"}, o_bus_be, e_be[beat]);
          chk({tag, "_we"}, o_bus_we, we);
          if (we) chk({tag, "_wdata"}, o_bus_wdata & be_mask(e_be[beat]), e_w[beat]);
          if (rst_b1 && beat == 1) begin
            rst_n = 1'b0; rst_hit = 1; done = 1; req_valid = 1'b0;
          end else if (beat == 0 && wc < wait0) begin
            wc++;
          end else begin
            bus_ready = 1'b1;
            bus_rdata = (beat == 0) ? rd0 : rd1;
            beat++;
          end
        end
      end
    end

    if (rst_b1) begin
      chk({tag, "_reached_beat1"}, rst_hit, 1);
      @(negedge clk);
      chk({tag, "_rst_busvalid"}, o_bus_valid, 0);
      chk({tag, "_rst_rspvalid"}, o_rsp_valid, 0);
      chk({tag, "_rst_ready"}, o_req_ready, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk({tag, "_no_rsp"}, o_rsp_valid, 0);
      end
    end else begin
      bus_ready = 1'b0;
      chk({tag, "_rsp_seen"}, seen, 1);
      chk({tag, "_latency"}, rsp_c, e_lat);
      chk({tag, "_nbeats"}, beat, nbeats);
      chk({tag, "_err"}, obs_err, e_err);
      chk({tag, "_rdata"}, obs_rdata, e_res);
      @(negedge clk);
      chk({tag, "_pulse_end"}, o_rsp_valid, 0);
      chk({tag, "_rdata_hold"}, o_rsp_rdata, e_res);
      chk({tag, "_ready_again"}, o_req_ready, 1);
      last_rdata = obs_rdata;
      $display("txn %s sel=%0d we=%0d size=%0d uns=%0d addr=%08h rdata=%08h err=%0d lat=%0d",
               tag, s, we, size, uns, addr, obs_rdata, obs_err, rsp_c);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready_a", ifa.req_ready, 1);
    chk("reset_ready_e", ife.req_ready, 1);
    chk("reset_busvalid_a", ifa.bus_valid, 0);
    chk("reset_be_a", ifa.bus_be, 0);
    chk("reset_addr_a", ifa.bus_addr, 0);
    chk("reset_rspvalid_a", ifa.rsp_valid, 0);
    chk("reset_rsperr_e", ife.rsp_err, 0);
    chk("reset_rdata_a", ifa.rsp_rdata, 0);
    rst_n = 1'b1;

    run_req(0, 0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 32'h0, 0, 0, 0, "t1_lb");
    chk("t1_lb_const", last_rdata, 32'hFFFF_FF80);
    run_req(0, 0, 2'd0, 1, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 32'h0, 0, 0, 0, "t1_lbu");
    chk("t1_lbu_const", last_rdata, 32'h0000_0080);
    run_req(0, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'h0, 0, 0, 0, "t2_sh");
    run_req(0, 0, 2'd2, 0, 32'h0000_3003, 32'h0, 32'h4433_2211, 32'h8877_6655, 0, 0, 0, "t3_lw_split");
    chk("t3_const", last_rdata, 32'h7766_5544);
    run_req(1, 1, 2'd2, 0, 32'h0000_3002, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0, "t4_sw_err");
    run_req(0, 1, 2'd2, 0, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 32'h0, 5, 1, 0, "t5_wait");
    run_req(0, 0, 2'd1, 0, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0000_00FF, 2, 0, 0, "wrap_lh");
    run_req(0, 0, 2'd3, 0, 32'h0000_6000, 32'h0, 32'h0, 32'h0, 0, 0, 0, "illegal_size");
    run_req(0, 0, 2'd2, 0, 32'h0000_5002, 32'h0, $urandom, $urandom, 1, 0, 1, "t6_rst");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ra, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
